// File: rtl/calc_pkg.sv
// Shared opcodes, FSM encoding and default width for the calculator pipeline.
package calc_pkg;
  localparam int CALC_W = 6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/calc_alu_seq_if.sv
// Operand/result bundle between the entry FSM, the ALU and the display stage.
interface calc_alu_seq_if
  import calc_pkg::*;
#(
  parameter int W = CALC_W
);
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           flag;
  logic [1:0]     opsel;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           neg;
  logic           err;
  logic           busy;
  logic           done;

  modport master (
    output A, B, flag, opsel,
    input  result, remainder, neg, err, busy, done
  );

  modport slave (
    input  A, B, flag, opsel,
    output result, remainder, neg, err, busy, done
  );
endinterface

// File: rtl/calc_alu_seq_sync_rise.sv
// Three-flop synchronizer with rising-edge detect on the synchronized level.
module sync_rise (
  input  logic clk,
  input  logic resetN,
  input  logic d_i,
  output logic rise_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/calc_alu_seq.sv
// Sequential ALU: add/sub in one cycle, shift-add multiply and restoring
// divide one bit per cycle, result held with done until the next start.
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input logic           clk,
  input logic           resetN,
  calc_alu_seq_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  // sh: multiplicand (mul) or dividend shifting into quotient (div)
  logic [2*W-1:0] sh_q, sh_d;
  // mp: multiplier (mul) or partial remainder (div)
  logic [W-1:0]   mp_q, mp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fin_q, fin_d;
  logic [2*W-1:0] result_q, result_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           neg_q, neg_d, err_q, err_d;

  logic           start;
  logic [W:0]     div_sh, div_trial;

  sync_rise u_sync (
    .clk    (clk),
    .resetN (resetN),
    .d_i    (bus.flag),
    .rise_o (start)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    mp_d      = mp_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    result_d  = result_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    err_d     = err_q;
    div_sh    = {mp_q, sh_q[W-1]};
    div_trial = div_sh - {1'b0, b_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.opsel;
          neg_d   = 1'b0;
          err_d   = 1'b0;
          acc_d   = '0;
          sh_d    = {{W{1'b0}}, bus.A};
          mp_d    = (bus.opsel == OP_DIV) ? '0 : bus.B;
          cnt_d   = CW'(W - 1);
          fin_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_d = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
            rem_d    = '0;
            state_d  = S_DONE;
          end
          OP_SUB: begin
            result_d = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
            neg_d    = (a_q < b_q);
            rem_d    = '0;
            state_d  = S_DONE;
          end
          OP_MUL: begin
            if (fin_q) begin
              result_d = acc_q;
              rem_d    = '0;
              state_d  = S_DONE;
            end else begin
              if (mp_q[0]) acc_d = acc_q + sh_q;
              sh_d = sh_q << 1;
              mp_d = mp_q >> 1;
            end
          end
          default: begin
            if (b_q == '0) begin
              result_d = '0;
              rem_d    = a_q;
              err_d    = 1'b1;
              state_d  = S_DONE;
            end else if (fin_q) begin
              result_d = {{W{1'b0}}, sh_q[W-1:0]};
              rem_d    = mp_q;
              state_d  = S_DONE;
            end else if (!div_trial[W]) begin
              mp_d = div_trial[W-1:0];
              sh_d = {sh_q[2*W-2:0], 1'b1};
            end else begin
              mp_d = div_sh[W-1:0];
              sh_d = {sh_q[2*W-2:0], 1'b0};
            end
          end
        endcase
        // Iteration count only matters for the multi-cycle ops
        if ((op_q == OP_MUL || (op_q == OP_DIV && b_q != '0)) && !fin_q) begin
          if (cnt_q == '0) fin_d = 1'b1;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      mp_q     <= '0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      mp_q     <= mp_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.remainder = rem_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == S_EXEC);
  assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed self-checking bench for calc_alu_seq with W=6.
module tb_calc_alu_seq;
  import calc_pkg::*;

  logic clk;
  logic resetN;
  int   checks;
  int   failures;

  calc_alu_seq_if #(.W(6)) bus ();

  calc_alu_seq #(.W(6)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive operands and raise flag just after an edge; the next edge is k.
  task automatic start_op(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    @(posedge clk);
    #1;
    bus.A     = a;
    bus.B     = b;
    bus.opsel = op;
    bus.flag  = 1'b1;
  endtask

  task automatic drop_flag();
    bus.flag = 1'b0;
    edges(4);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.flag = 1'b0; bus.A = '0; bus.B = '0; bus.opsel = OP_ADD;
    edges(2);
    checks++; if (bus.result !== 12'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
    checks++; if (bus.remainder !== 6'd0) begin failures++; $display("FAIL reset_rem got=%0d exp=0", bus.remainder); end
    checks++; if ({bus.neg, bus.err, bus.busy, bus.done} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.neg, bus.err, bus.busy, bus.done}); end
    resetN = 1'b1;
    edges(2);
  endtask

  task automatic test_add();
    start_op(6'd63, 6'd63, OP_ADD);
    edges(2); // after k+1
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL add_busy_k1 got=%b exp=0", bus.busy); end
    edges(1); // after k+2
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin failures++; $display("FAIL add_busy_k2 got=%b exp=10", {bus.busy, bus.done}); end
    edges(1); // after k+3
    checks++; if (bus.result !== 12'd126) begin failures++; $display("FAIL add_result got=%0d exp=126", bus.result); end
    checks++; if ({bus.neg, bus.err, bus.busy, bus.done} !== 4'b0001) begin failures++; $display("FAIL add_flags got=%b exp=0001", {bus.neg, bus.err, bus.busy, bus.done}); end
    drop_flag();
  endtask

  task automatic test_sub();
    start_op(6'd5, 6'd9, OP_SUB);
    edges(4);
    checks++; if (bus.result !== 12'hFFC) begin failures++; $display("FAIL sub_neg_result got=%0h exp=ffc", bus.result); end
    checks++; if ({bus.neg, bus.done} !== 2'b11) begin failures++; $display("FAIL sub_neg_flags got=%b exp=11", {bus.neg, bus.done}); end
    drop_flag();
    start_op(6'd9, 6'd5, OP_SUB);
    edges(4);
    checks++; if (bus.result !== 12'd4) begin failures++; $display("FAIL sub_pos_result got=%0d exp=4", bus.result); end
    checks++; if ({bus.neg, bus.done} !== 2'b01) begin failures++; $display("FAIL sub_pos_flags got=%b exp=01", {bus.neg, bus.done}); end
    drop_flag();
  endtask

  task automatic test_mul();
    start_op(6'd63, 6'd63, OP_MUL);
    edges(3); // after k+2
    for (int e = 3; e <= 8; e++) begin
      edges(1);
      checks++; if ({bus.busy, bus.done} !== 2'b10) begin failures++; $display("FAIL mul_busy_k%0d got=%b exp=10", e, {bus.busy, bus.done}); end
    end
    edges(1); // after k+9
    checks++; if (bus.result !== 12'd3969) begin failures++; $display("FAIL mul_result got=%0d exp=3969", bus.result); end
    checks++; if ({bus.remainder, bus.busy, bus.done} !== 8'b00000001) begin failures++; $display("FAIL mul_flags got=%b exp=00000001", {bus.remainder, bus.busy, bus.done}); end
    drop_flag();
  endtask

  task automatic test_div();
    start_op(6'd45, 6'd7, OP_DIV);
    edges(9); // after k+8
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL div_done_k8 got=%b exp=0", bus.done); end
    edges(1); // after k+9
    checks++; if (bus.result !== 12'd6) begin failures++; $display("FAIL div_quot got=%0d exp=6", bus.result); end
    checks++; if (bus.remainder !== 6'd3) begin failures++; $display("FAIL div_rem got=%0d exp=3", bus.remainder); end
    checks++; if ({bus.err, bus.done} !== 2'b01) begin failures++; $display("FAIL div_flags got=%b exp=01", {bus.err, bus.done}); end
    drop_flag();
    start_op(6'd12, 6'd0, OP_DIV);
    edges(4); // after k+3
    checks++; if (bus.result !== 12'd0) begin failures++; $display("FAIL div0_result got=%0d exp=0", bus.result); end
    checks++; if (bus.remainder !== 6'd12) begin failures++; $display("FAIL div0_rem got=%0d exp=12", bus.remainder); end
    checks++; if ({bus.err, bus.busy, bus.done} !== 3'b101) begin failures++; $display("FAIL div0_flags got=%b exp=101", {bus.err, bus.busy, bus.done}); end
    drop_flag();
  endtask

  task automatic test_mid_flag();
    start_op(6'd63, 6'd63, OP_MUL);
    edges(4); // after k+3: operands already latched
    bus.A = 6'd1; bus.B = 6'd2; bus.opsel = OP_ADD;
    edges(1); // after k+4
    bus.flag = 1'b0;
    edges(1); // after k+5
    bus.flag = 1'b1;
    edges(4); // after k+9
    checks++; if (bus.result !== 12'd3969) begin failures++; $display("FAIL midflag_result got=%0d exp=3969", bus.result); end
    checks++; if ({bus.err, bus.busy, bus.done} !== 3'b001) begin failures++; $display("FAIL midflag_flags got=%b exp=001", {bus.err, bus.busy, bus.done}); end
    edges(4); // no second operation should have started
    checks++; if ({bus.result, bus.busy, bus.done} !== {12'd3969, 2'b01}) begin failures++; $display("FAIL midflag_hold got=%0d/%b exp=3969/01", bus.result, {bus.busy, bus.done}); end
    drop_flag();
  endtask

  task automatic test_reset_mid();
    start_op(6'd7, 6'd3, OP_MUL);
    edges(7); // after k+6
    resetN = 1'b0;
    bus.flag = 1'b0;
    #1;
    checks++; if (bus.result !== 12'd0) begin failures++; $display("FAIL rstmid_result got=%0d exp=0", bus.result); end
    checks++; if ({bus.remainder, bus.neg, bus.err, bus.busy, bus.done} !== 10'd0) begin failures++; $display("FAIL rstmid_flags got=%b exp=0", {bus.remainder, bus.neg, bus.err, bus.busy, bus.done}); end
    edges(2);
    resetN = 1'b1;
    edges(2);
    start_op(6'd1, 6'd2, OP_ADD);
    edges(4);
    checks++; if ({bus.result, bus.done} !== {12'd3, 1'b1}) begin failures++; $display("FAIL rstmid_restart got=%0d/%b exp=3/1", bus.result, bus.done); end
    drop_flag();
  endtask

  task automatic test_back_to_back();
    start_op(6'd10, 6'd20, OP_ADD);
    edges(4);
    checks++; if ({bus.result, bus.done} !== {12'd30, 1'b1}) begin failures++; $display("FAIL b2b_first got=%0d/%b exp=30/1", bus.result, bus.done); end
    drop_flag();
    checks++; if ({bus.result, bus.done} !== {12'd30, 1'b1}) begin failures++; $display("FAIL b2b_hold got=%0d/%b exp=30/1", bus.result, bus.done); end
    start_op(6'd7, 6'd8, OP_ADD);
    edges(2); // after k+1
    checks++; if ({bus.result, bus.done} !== {12'd30, 1'b1}) begin failures++; $display("FAIL b2b_k1 got=%0d/%b exp=30/1", bus.result, bus.done); end
    edges(1); // after k+2
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin failures++; $display("FAIL b2b_k2 got=%b exp=10", {bus.busy, bus.done}); end
    edges(1); // after k+3
    checks++; if ({bus.result, bus.done} !== {12'd15, 1'b1}) begin failures++; $display("FAIL b2b_second got=%0d/%b exp=15/1", bus.result, bus.done); end
    drop_flag();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_mid_flag();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
